// File: rtl/mul_div_unit.sv
// Sequential 32-bit multiply/divide unit: radix-2 shift-add MUL/MULHU and
// restoring DIVU/REMU, one bit per cycle, with a register-file write-back port.
`timescale 1ns/1ps
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic [31:0] w_result;

  // r_hi/r_lo hold {partial product, multiplier} for MUL and
  // {partial remainder, dividend/quotient} for DIV.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 33'd0);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_b};

  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (r_op[1]) begin
      w_hi_nx = w_diff[33] ? w_shift[31:0] : w_diff[31:0];
      w_lo_nx = {r_lo[30:0], ~w_diff[33]};
    end else begin
      w_hi_nx = w_sum[32:1];
      w_lo_nx = {w_sum[0], r_lo[31:1]};
    end
  end

  always_comb begin
    w_result = w_lo_nx;
    case (r_op)
      2'b00:   w_result = w_lo_nx;
      2'b01:   w_result = w_hi_nx;
      2'b10:   w_result = w_lo_nx;
      default: w_result = w_hi_nx;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (kill) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_a    <= src_a;
            r_b    <= src_b;
            r_rd   <= rd;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= op[1] ? src_a : src_b;
            r_busy <= 1'b1;
            if (op[1] && (src_b == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_we    <= (rd != '0);
              r_waddr <= rd;
              r_wdata <= op[0] ? src_a : '1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_we    <= (r_rd != '0);
            r_waddr <= r_rd;
            r_wdata <= w_result;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_we    <= 1'b0;
          r_waddr <= '0;
          r_wdata <= '0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign wb_we   = r_we;
  assign wb_addr = r_waddr;
  assign wb_data = r_wdata;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected write-backs,
// a negedge monitor pops and checks them whenever done pulses.
`timescale 1ns/1ps
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  rd = '0;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .src_a(src_a), .src_b(src_b), .rd(rd), .busy(busy), .done(done),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none (addr %0d data %0h)",
                   cyc, wb_addr, wb_data);
        end else begin
          e = sb.pop_front();
          check("wb_we", {31'b0, wb_we}, {31'b0, e.we});
          check("wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
          check("wb_data", wb_data, e.data);
          check("done_cycle", cyc, e.due);
          check("busy_at_done", {31'b0, busy}, 32'd1);
        end
      end else if (wb_we !== 1'b0 || wb_addr !== '0 || wb_data !== '0) begin
        checks++;
        errors++;
        $display("FAIL idle_outputs: got we=%0b addr=%0d data=%0h expected 0 at cycle %0d",
                 wb_we, wb_addr, wb_data, cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic expect_done,
                       input logic [31:0] exp_data, input int unsigned lat);
    exp_t e;
    op = o; src_a = a; src_b = b; rd = r; start = 1'b1;
    if (expect_done) begin
      e.we = (r != 5'd0); e.addr = r; e.data = exp_data; e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned exp_busy);
    int unsigned n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, exp_busy);
  endtask

  initial begin
    #3;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wb", {wb_we, wb_addr, wb_data[25:0]}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    issue(2'b00, 32'd5, 32'd4, 5'd3, 1'b1, 32'd20, 33);
    repeat (4) @(negedge clk);
    check("calc_busy", {31'b0, busy}, 32'd1);
    check("calc_done", {31'b0, done}, 32'd0);
    wait_idle("mul_busy_len", 29);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1'b1, 32'hFFFFFFFE, 33);
    wait_idle("mulhu_busy_len", 33);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 1'b1, 32'h00000001, 33);
    wait_idle("mul_ff_busy_len", 33);
    issue(2'b01, 32'h80000000, 32'd4, 5'd4, 1'b1, 32'd2, 33);
    wait_idle("mulhu2_busy_len", 33);

    issue(2'b10, 32'd100, 32'd7, 5'd7, 1'b1, 32'd14, 33);
    wait_idle("divu_busy_len", 33);
    issue(2'b11, 32'd100, 32'd7, 5'd8, 1'b1, 32'd2, 33);
    wait_idle("remu_busy_len", 33);
    issue(2'b10, 32'hFFFFFFFF, 32'd16, 5'd15, 1'b1, 32'h0FFFFFFF, 33);
    wait_idle("divu_big_busy_len", 33);
    issue(2'b11, 32'hFFFFFFFF, 32'd16, 5'd16, 1'b1, 32'd15, 33);
    wait_idle("remu_big_busy_len", 33);

    issue(2'b10, 32'd100, 32'd0, 5'd9, 1'b1, 32'hFFFFFFFF, 1);
    wait_idle("div0_busy_len", 1);
    issue(2'b11, 32'd100, 32'd0, 5'd10, 1'b1, 32'd100, 1);
    wait_idle("rem0_busy_len", 1);

    issue(2'b00, 32'd6, 32'd7, 5'd0, 1'b1, 32'd42, 33);
    wait_idle("rd0_busy_len", 33);

    // Mid-operation start with different operands must be ignored.
    issue(2'b00, 32'd9, 32'd3, 5'd11, 1'b1, 32'd27, 33);
    repeat (9) @(negedge clk);
    op = 2'b01; src_a = 32'd100; src_b = 32'd100; rd = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore_start_busy_len", 23);

    issue(2'b10, 32'd1000, 32'd10, 5'd13, 1'b0, 32'd0, 0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    issue(2'b00, 32'd123, 32'd456, 5'd14, 1'b0, 32'd0, 0);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_wb", {wb_we, done, wb_addr, wb_data[24:0]}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(2'b00, 32'd123, 32'd456, 5'd14, 1'b1, 32'd56088, 33);
    wait_idle("post_rst_busy_len", 33);
    @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits and register addresses at 5 bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port kill  input  1  synchronous abort; discards the in-flight operation.
REQ-006 SHALL have port op  input  2  00 MUL (low 32), 01 MULHU (high 32, unsigned), 10 DIVU, 11 REMU.
REQ-007 SHALL have port src_a  input  32  operand A / dividend, driven from register-file RD1.
REQ-008 SHALL have port src_b  input  32  operand B / divisor, driven from register-file RD2.
REQ-009 SHALL have port rd  input  5  destination register index.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight; stall indication to control.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port wb_we  output  1  register-file write enable (to WE3).
REQ-013 SHALL have port wb_addr  output  5  register-file write index (to A3).
REQ-014 SHALL have port wb_data  output  32  register-file write data (to WD3).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL, in IDLE with start=1 and kill=0, latch op, src_a, src_b, rd, clear iteration counter to 0, and enter CALC (or DONE per REQ-021).
REQ-017 SHALL ignore start whenever the FSM is not in IDLE; latched operands are never overwritten mid-operation.
REQ-018 SHALL perform MUL/MULHU as radix-2 shift-add, one bit per cycle, 64-bit unsigned product.
REQ-019 SHALL perform DIVU/REMU as restoring division, one quotient bit per cycle, 32-bit quotient and remainder, unsigned.
REQ-020 SHALL spend exactly 32 cycles in CALC, then enter DONE; counter wraps 31 -> exit, never re-enters CALC.
REQ-021 SHALL, for DIVU/REMU with src_b = 0, skip CALC and go IDLE -> DONE directly; result DIVU = 32'hFFFFFFFF, REMU = src_a.
REQ-022 SHALL, in DONE, assert done=1 for exactly one cycle, drive wb_addr = latched rd, wb_data = result, then return to IDLE.
REQ-023 SHALL assert wb_we only in DONE and only when latched rd != 0; done still pulses when rd = 0.
REQ-024 SHALL hold wb_we=0, done=0, wb_addr=0, wb_data=0 in IDLE and CALC.
REQ-025 SHALL drive busy=1 in CALC and DONE, 0 in IDLE; busy is registered (rises the cycle after start is accepted).
REQ-026 SHALL give latency: start sampled at edge N -> done/wb_we high in cycle following edge N+33 (normal) or N+1 (divide-by-zero).
REQ-027 SHALL, on kill=1 in any state, go to IDLE at the next edge with no done, no wb_we; kill has priority over start and over DONE completion.
REQ-028 SHALL permit a new start in the first IDLE cycle after DONE (back-to-back issue, 34-cycle pitch).

Reset
REQ-029 SHALL, while rst=1, immediately force FSM to IDLE and busy, done, wb_we, wb_addr, wb_data, counter and operand registers to 0, independent of clk.
REQ-030 SHALL, on rst asserted mid-CALC or in DONE, discard the operation with no register-file write after rst deasserts.
REQ-031 SHALL accept start on the first rising clk edge after rst deasserts.

Verification
REQ-032 SHALL test: op=00, src_a=5, src_b=4, rd=3 -> 33 edges later one-cycle done, wb_we=1, wb_addr=3, wb_data=20.
REQ-033 SHALL test: op=01, src_a=src_b=32'hFFFFFFFF -> wb_data=32'hFFFFFFFE; op=00 same operands -> wb_data=32'h00000001.
REQ-034 SHALL test: op=10/11, src_a=100, src_b=7 -> wb_data 14 / 2; src_b=0 -> wb_data 32'hFFFFFFFF / 100 one edge after start, busy for one cycle only.
REQ-035 SHALL test: rd=0, op=00, 6x7 -> done pulses, wb_we stays 0.
REQ-036 SHALL test: start re-asserted at cycle 10 of CALC with different operands -> ignored, original result written; then kill at cycle 10 of a second operation -> IDLE next edge, no done, no wb_we.
REQ-037 SHALL test: rst pulsed asynchronously between clock edges at CALC cycle 20 -> all outputs 0 immediately, no write afterwards; a fresh start after release completes normally.
